// File: rtl/tlc_timer.sv
// tlc_timer -- tick generator and 4-bit countdown timer for the traffic light
// controller.
//
// A prescaler divides clk into a one-cycle clk_en strobe. The strobe paces
// the controller FSM and also gates the countdown timer, so the timer and the
// controller always advance on the same clk edge.
//
// Parameters
//   DIV       clk cycles per strobe in normal mode (>=2)
//   FAST_DIV  clk cycles per strobe when fast=1 (>=2, <=DIV)
//   PRE_W     prescaler width, derived from DIV
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-high reset
//   fast        in   1 = FAST_DIV period, 0 = DIV period
//   timer_load  in   load timer_init on the next strobe edge
//   timer_en    in   decrement on the next strobe edge
//   timer_init  in   [3:0] load value
//   clk_en      out  registered strobe, high for one clk per period
//   timer_out   out  [3:0] current count
//   expired     out  one-clk pulse when the count steps 1 -> 0 by decrement
module tlc_timer #(
  parameter int DIV      = 50_000_000,
  parameter int FAST_DIV = 4,
  parameter int PRE_W    = $clog2(DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fast,
  input  logic       timer_load,
  input  logic       timer_en,
  input  logic [3:0] timer_init,
  output logic       clk_en,
  output logic [3:0] timer_out,
  output logic       expired
);

  localparam logic [31:0] DIV_M1  = 32'(DIV - 1);
  localparam logic [31:0] FAST_M1 = 32'(FAST_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [31:0]      lim_m1;
  logic             wrap;

  // The >= (rather than ==) lets a switch to the shorter period mid-count
  // strobe on the very next edge instead of running past the new limit.
  assign lim_m1 = fast ? FAST_M1 : DIV_M1;
  assign wrap   = 32'(pre_cnt) >= lim_m1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      clk_en  <= 1'b0;
    end else if (wrap) begin
      pre_cnt <= '0;
      clk_en  <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
      clk_en  <= 1'b0;
    end
  end

  // Commands are acted on only at the edge where the registered strobe is
  // high; load beats enable, and the count saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_out <= 4'd0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (clk_en) begin
        if (timer_load) begin
          timer_out <= timer_init;
        end else if (timer_en && timer_out != 4'd0) begin
          timer_out <= timer_out - 4'd1;
          expired   <= (timer_out == 4'd1);
        end
      end
    end
  end

endmodule
